i2c_cmd_sequencer: RTL and testbench
====================================

Name: i2c_cmd_sequencer

Overview:
- AXI-Lite master that sequences the axi_i2c_bridge (OpenCores i2c_master_top register file) to run single-byte I2C register transactions.
- Accepts one command (device, register, data, direction) on a valid/ready port and issues the required PRER/CTR/TXR/CR writes and SR/RXR reads.
- Polls TIP after every byte, checks RxACK, and returns a one-cycle response with read data and an error code.
- Sits between system control logic and the bridge's AXI slave port.

Parameters:
- C_AXI_ADDR_WIDTH, 28, AXI address width; matches the bridge.
- C_AXI_DATA_WIDTH, 32, AXI data width; the register byte is in bits [7:0].
- BASE_ADDR, 0, bridge base address.
- REG_STRIDE_LOG2, 2; register n is at BASE_ADDR + (n << REG_STRIDE_LOG2). Map: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR/RXR, 4 CR/SR.
- POLL_LIMIT, 4096, maximum SR reads per byte before timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock
- axi_reset  in  1  asynchronous, active-high reset
- prescale  in  16  I2C prescaler; sampled at reset release
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_rw  in  1  0 = write, 1 = read
- cmd_dev  in  7  I2C device address
- cmd_reg  in  8  register address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read byte; 0 for writes
- rsp_err  out  2  00 ok, 01 NACK, 10 AXI error, 11 timeout
- busy  out  1  high when not IDLE
- m_axi_awvalid/awready/awaddr/awprot  out/in/out/out  1/1/C_AXI_ADDR_WIDTH/3  write address; awprot = 0
- m_axi_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/C_AXI_DATA_WIDTH/4  write data; wstrb = 4'h1
- m_axi_bvalid/bready/bresp  in/out/in  1/1/2  write response
- m_axi_arvalid/arready/araddr/arprot  out/in/out/out  1/1/C_AXI_ADDR_WIDTH/3  read address; arprot = 0
- m_axi_rvalid/rready/rdata/rresp  in/out/in  1/1/C_AXI_DATA_WIDTH/2  read data

Behaviour:
- Reset values: all valid, ready and rsp outputs 0; busy 1; state INIT.

AXI single-transaction engine:
- Write: awvalid and wvalid assert together; each drops independently on its own ready.
- After both handshakes, bready is held 1 until bvalid.
- Read: arvalid is held until arready, then rready is held 1 until rvalid.
- Exactly one transaction is outstanding at a time.
- bresp or rresp not equal to 0 gives error 10.

INIT (once after reset), in order:
- PRERlo = prescale[7:0]
- PRERhi = prescale[15:8]
- CTR = 0x80
- Then go to IDLE. An AXI error during INIT retries INIT from the start.

IDLE:
- cmd_ready = 1. Capture the command on cmd_valid && cmd_ready.

Byte step (TX): write TXR, write CR, then POLL.

POLL:
- Read SR repeatedly until SR[1] (TIP) = 0.
- If SR[7] (RxACK) = 1 on an address or register byte, go to ABORT with error 01.

Write command:
- TX(dev<<1, CR 0x90)
- TX(reg, CR 0x10)
- TX(wdata, CR 0x50)

Read command:
- TX(dev<<1, CR 0x90)
- TX(reg, CR 0x10)
- TX(dev<<1 | 1, CR 0x90)
- Write CR 0x68, POLL, then read RXR into rsp_rdata.

ABORT:
- Write CR 0x40 (STOP), POLL TIP, then go to DONE. This write is skipped when the cause is an AXI error.

DONE:
- rsp_valid = 1 for one cycle, then IDLE.
- Latency: a new command is accepted no earlier than the cycle after rsp_valid.

Other rules:
- cmd_valid outside IDLE is ignored.
- Reset mid-transaction aborts immediately. The AXI valids drop and INIT reruns; the bridge is not stopped explicitly.

Optional Feature:
- Macro I2C_SEQ_TIMEOUT_EN.
- Defined: a counter (width $clog2(POLL_LIMIT+1)) clears at each POLL entry and increments per SR read. Reaching POLL_LIMIT gives error 11 and goes to ABORT; the ABORT poll is itself bounded and then forces DONE.
- Undefined: POLL waits indefinitely; code 11 is never produced.

Decomposition:
- Package i2c_seq_pkg holds:
  - register index constants (PRERLO..CR_SR)
  - CR command constants (CMD_STA_WR 0x90, CMD_WR 0x10, CMD_STO_WR 0x50, CMD_RD_NACK_STO 0x68, CMD_STO 0x40)
  - SR bit positions
  - the rsp_err enum
  - the state enum
- Sub-module axil_single_master owns the AXI engine: req/we/addr/wdata in, done/rdata/err out.

Test Plan:
- prescale 0x00C7, reset released → AXI writes 0xC7@0x00, 0x00@0x04, 0x80@0x08, then cmd_ready = 1.
- Write dev 0x50, reg 0x12, data 0xA5; slave model ACKs; TIP clears after 3 reads → TXR/CR writes 0xA0/0x90, 0x12/0x10, 0xA5/0x50; rsp_err 00, rsp_rdata 0x00.
- Read dev 0x50, reg 0x12; model returns RXR 0x3C → CR sequence 0x90, 0x10, 0x90, 0x68; rsp_rdata 0x3C, err 00.
- SR returns RxACK = 1 after the address byte → CR 0x40 written, rsp_err 01, no register byte sent.
- bresp = 2'b10 on the TXR write → no further AXI traffic, rsp_err 10, returns to IDLE.
- With I2C_SEQ_TIMEOUT_EN and POLL_LIMIT 8, TIP stuck at 1 → exactly 8 SR reads, then STOP, rsp_err 11. Assert axi_reset mid-poll → INIT writes restart.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared constants and types for the I2C command sequencer: bridge register
// indices, CR command bytes, SR bit positions, response codes and FSM states.
package i2c_seq_pkg;

  // Register indices into the i2c_master_top register file
  localparam logic [2:0] REG_PRERLO  = 3'd0;
  localparam logic [2:0] REG_PRERHI  = 3'd1;
  localparam logic [2:0] REG_CTR     = 3'd2;
  localparam logic [2:0] REG_TXR_RXR = 3'd3;
  localparam logic [2:0] REG_CR_SR   = 3'd4;

  // CR command bytes
  localparam logic [7:0] CMD_STA_WR      = 8'h90;
  localparam logic [7:0] CMD_WR          = 8'h10;
  localparam logic [7:0] CMD_STO_WR      = 8'h50;
  localparam logic [7:0] CMD_RD_NACK_STO = 8'h68;
  localparam logic [7:0] CMD_STO         = 8'h40;

  // Core enable value written to CTR during init
  localparam logic [7:0] CTR_EN = 8'h80;

  // SR bit positions
  localparam int SR_TIP   = 1;
  localparam int SR_RXACK = 7;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_AXI     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } rsp_err_e;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_TXR,
    S_CR,
    S_POLL,
    S_RXR,
    S_ABORT,
    S_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    E_IDLE,
    E_WRITE,
    E_BRESP,
    E_ADDR_RD,
    E_RDATA
  } eng_state_e;

endpackage

// File: rtl/i2c_cmd_sequencer_axil.sv
// Single-outstanding AXI-Lite master. A one-cycle req starts one register
// write or read; done pulses for one cycle with the low read byte and an
// error flag (any non-OKAY response).
module axil_single_master
  import i2c_seq_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req,
  input  logic                        we,
  input  logic [C_AXI_ADDR_WIDTH-1:0] addr,
  input  logic [7:0]                  wdata,
  output logic                        done,
  output logic [7:0]                  rdata,
  output logic                        err,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [C_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp
);

  eng_state_e st;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'h1;

  // Only the register byte of read data is meaningful
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^m_axi_rdata[C_AXI_DATA_WIDTH-1:8];

  // Transaction engine: address/data channels drop independently on ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= E_IDLE;
      done          <= 1'b0;
      rdata         <= 8'h00;
      err           <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        E_IDLE: begin
          if (req) begin
            if (we) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_awaddr  <= addr;
              m_axi_wdata   <= {{(C_AXI_DATA_WIDTH-8){1'b0}}, wdata};
              st            <= E_WRITE;
            end else begin
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= addr;
              st            <= E_ADDR_RD;
            end
          end
        end
        E_WRITE: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            st           <= E_BRESP;
          end
        end
        E_BRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            done         <= 1'b1;
            err          <= (m_axi_bresp != 2'b00);
            st           <= E_IDLE;
          end
        end
        E_ADDR_RD: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            st            <= E_RDATA;
          end
        end
        E_RDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            done         <= 1'b1;
            rdata        <= m_axi_rdata[7:0];
            err          <= (m_axi_rresp != 2'b00);
            st           <= E_IDLE;
          end
        end
        default: st <= E_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Sequences the OpenCores i2c_master_top register file over AXI-Lite to run
// single-byte I2C register reads and writes.
// Optional macro I2C_SEQ_TIMEOUT_EN bounds every TIP poll to POLL_LIMIT SR
// reads and reports code 11 on expiry; without it polls wait indefinitely.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int                          C_AXI_ADDR_WIDTH = 28,
  parameter int                          C_AXI_DATA_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
  parameter int                          REG_STRIDE_LOG2  = 2,
  parameter int                          POLL_LIMIT       = 4096
) (
  input  logic                        clk,
  input  logic                        axi_reset,
  input  logic [15:0]                 prescale,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rw,
  input  logic [6:0]                  cmd_dev,
  input  logic [7:0]                  cmd_reg,
  input  logic [7:0]                  cmd_wdata,
  output logic                        rsp_valid,
  output logic [7:0]                  rsp_rdata,
  output logic [1:0]                  rsp_err,
  output logic                        busy,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [C_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp
);

  seq_state_e                  state;
  logic [1:0]                  init_idx;
  logic                        pending;
  logic                        req;
  logic                        req_we;
  logic [C_AXI_ADDR_WIDTH-1:0] req_addr;
  logic [7:0]                  req_wdata;
  logic                        eng_done;
  logic [7:0]                  eng_rdata;
  logic                        eng_err;
  logic [7:0]                  prescale_hi;
  logic                        rw_q;
  logic [6:0]                  dev_q;
  logic [7:0]                  reg_q;
  logic [7:0]                  wdata_q;
  // byte_idx: 0 device address, 1 register, 2 data or repeated-start
  // address, 3 read-back phase (CR only, no TXR)
  logic [1:0]                  byte_idx;
  logic                        aborting;
  rsp_err_e                    err_q;
  logic [7:0]                  tx_byte;
  logic [7:0]                  cr_byte;
  logic                        nack_checked;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_LIMIT + 1);
  logic [PCW-1:0] poll_cnt;
`else
  localparam int unused_poll_limit = POLL_LIMIT;
`endif

  assign rsp_err = err_q;

  function automatic logic [C_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [2:0] idx);
    return BASE_ADDR + (C_AXI_ADDR_WIDTH'(idx) << REG_STRIDE_LOG2);
  endfunction

  // Byte and CR command for the current step of the command
  always_comb begin
    tx_byte      = {dev_q, 1'b0};
    cr_byte      = CMD_STA_WR;
    nack_checked = 1'b1;
    case (byte_idx)
      2'd0: begin
        tx_byte = {dev_q, 1'b0};
        cr_byte = CMD_STA_WR;
      end
      2'd1: begin
        tx_byte = reg_q;
        cr_byte = CMD_WR;
      end
      2'd2: begin
        tx_byte      = rw_q ? {dev_q, 1'b1} : wdata_q;
        cr_byte      = rw_q ? CMD_STA_WR : CMD_STO_WR;
        nack_checked = rw_q;
      end
      default: begin
        tx_byte      = 8'h00;
        cr_byte      = CMD_RD_NACK_STO;
        nack_checked = 1'b0;
      end
    endcase
  end

  axil_single_master #(
    .C_AXI_ADDR_WIDTH(C_AXI_ADDR_WIDTH),
    .C_AXI_DATA_WIDTH(C_AXI_DATA_WIDTH)
  ) u_axil (
    .clk           (clk),
    .rst           (axi_reset),
    .req           (req),
    .we            (req_we),
    .addr          (req_addr),
    .wdata         (req_wdata),
    .done          (eng_done),
    .rdata         (eng_rdata),
    .err           (eng_err),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp)
  );

  // Sequencer FSM: each AXI step issues one req, then waits for eng_done
  always_ff @(posedge clk or posedge axi_reset) begin
    if (axi_reset) begin
      state       <= S_INIT;
      init_idx    <= 2'd0;
      pending     <= 1'b0;
      req         <= 1'b0;
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= 8'h00;
      prescale_hi <= 8'h00;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      byte_idx    <= 2'd0;
      aborting    <= 1'b0;
      err_q       <= ERR_OK;
      cmd_ready   <= 1'b0;
      busy        <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
      poll_cnt    <= '0;
`endif
    end else begin
      req       <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_INIT: begin
          if (!pending) begin
            pending <= 1'b1;
            req     <= 1'b1;
            req_we  <= 1'b1;
            case (init_idx)
              2'd0: begin
                req_addr    <= reg_addr(REG_PRERLO);
                req_wdata   <= prescale[7:0];
                prescale_hi <= prescale[15:8];
              end
              2'd1: begin
                req_addr  <= reg_addr(REG_PRERHI);
                req_wdata <= prescale_hi;
              end
              default: begin
                req_addr  <= reg_addr(REG_CTR);
                req_wdata <= CTR_EN;
              end
            endcase
          end else if (eng_done) begin
            pending <= 1'b0;
            if (eng_err) begin
              init_idx <= 2'd0;
            end else if (init_idx == 2'd2) begin
              init_idx  <= 2'd0;
              state     <= S_IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              init_idx <= init_idx + 2'd1;
            end
          end
        end
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            rw_q      <= cmd_rw;
            dev_q     <= cmd_dev;
            reg_q     <= cmd_reg;
            wdata_q   <= cmd_wdata;
            byte_idx  <= 2'd0;
            aborting  <= 1'b0;
            err_q     <= ERR_OK;
            rsp_rdata <= 8'h00;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_TXR;
          end
        end
        S_TXR, S_CR, S_RXR, S_ABORT, S_POLL: begin
          if (!pending) begin
            pending <= 1'b1;
            req     <= 1'b1;
            req_we  <= (state == S_TXR) || (state == S_CR) || (state == S_ABORT);
            case (state)
              S_TXR: begin
                req_addr  <= reg_addr(REG_TXR_RXR);
                req_wdata <= tx_byte;
              end
              S_CR: begin
                req_addr  <= reg_addr(REG_CR_SR);
                req_wdata <= cr_byte;
              end
              S_ABORT: begin
                req_addr  <= reg_addr(REG_CR_SR);
                req_wdata <= CMD_STO;
              end
              S_RXR: begin
                req_addr  <= reg_addr(REG_TXR_RXR);
                req_wdata <= 8'h00;
              end
              default: begin
                req_addr  <= reg_addr(REG_CR_SR);
                req_wdata <= 8'h00;
              end
            endcase
          end else if (eng_done) begin
            pending <= 1'b0;
            if (eng_err) begin
              // Bridge is unreachable: report and skip the STOP write
              if (!aborting) err_q <= ERR_AXI;
              rsp_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              case (state)
                S_TXR: state <= S_CR;
                S_CR, S_ABORT: begin
                  if (state == S_ABORT) aborting <= 1'b1;
                  state <= S_POLL;
`ifdef I2C_SEQ_TIMEOUT_EN
                  poll_cnt <= '0;
`endif
                end
                S_RXR: begin
                  rsp_rdata <= eng_rdata;
                  rsp_valid <= 1'b1;
                  state     <= S_DONE;
                end
                default: begin
                  if (!eng_rdata[SR_TIP]) begin
                    if (aborting) begin
                      rsp_valid <= 1'b1;
                      state     <= S_DONE;
                    end else if (eng_rdata[SR_RXACK] && nack_checked) begin
                      err_q    <= ERR_NACK;
                      aborting <= 1'b1;
                      state    <= S_ABORT;
                    end else if (byte_idx == 2'd3) begin
                      state <= S_RXR;
                    end else if (byte_idx == 2'd2) begin
                      if (rw_q) begin
                        byte_idx <= 2'd3;
                        state    <= S_CR;
                      end else begin
                        rsp_valid <= 1'b1;
                        state     <= S_DONE;
                      end
                    end else begin
                      byte_idx <= byte_idx + 2'd1;
                      state    <= S_TXR;
                    end
                  end
`ifdef I2C_SEQ_TIMEOUT_EN
                  else if (poll_cnt == PCW'(POLL_LIMIT - 1)) begin
                    // A stuck STOP poll gives up and reports anyway
                    if (aborting) begin
                      rsp_valid <= 1'b1;
                      state     <= S_DONE;
                    end else begin
                      err_q    <= ERR_TIMEOUT;
                      aborting <= 1'b1;
                      state    <= S_ABORT;
                    end
                  end else begin
                    poll_cnt <= poll_cnt + 1'b1;
                  end
`endif
                end
              endcase
            end
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
module tb_i2c_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] prescale = 16'h00C7;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b0;
  logic [6:0]  cmd_dev = 7'h00;
  logic [7:0]  cmd_reg = 8'h00;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [27:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(
    .C_AXI_ADDR_WIDTH(28), .C_AXI_DATA_WIDTH(32), .BASE_ADDR(28'h0),
    .REG_STRIDE_LOG2(2), .POLL_LIMIT(8)
  ) dut (
    .clk(clk), .axi_reset(rst), .prescale(prescale),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  // bridge model configuration (bench-owned)
  int         cr_base = 0, wr_base = 0, nack_cr = 0, berr_wr = 0;
  bit         tip_stuck = 1'b0;
  logic [7:0] rxr_val = 8'h00;
  // bridge model state (model-owned)
  int          wr_total = 0, cr_total = 0, sr_reads = 0, poll_cnt = 0, sr_at_stop = 0;
  logic [27:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        have_aw, have_w;
  logic [27:0] aw_q;
  logic [31:0] w_q;

  // AXI slave standing in for the bridge register file
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
      have_aw <= 1'b0; have_w <= 1'b0; aw_q <= '0; w_q <= '0;
    end else begin
      awready <= awvalid && !awready && !have_aw;
      wready  <= wvalid && !wready && !have_w && have_aw;
      if (awvalid && awready) begin have_aw <= 1'b1; aw_q <= awaddr; end
      if (wvalid && wready) begin have_w <= 1'b1; w_q <= wdata; end
      if (have_aw && have_w && !bvalid) begin
        have_aw <= 1'b0; have_w <= 1'b0; bvalid <= 1'b1;
        bresp <= (berr_wr != 0 && wr_total - wr_base + 1 == berr_wr) ? 2'b10 : 2'b00;
        log_addr.push_back(aw_q);
        log_data.push_back(w_q);
        wr_total <= wr_total + 1;
        if (aw_q == 28'h10) begin
          cr_total <= cr_total + 1;
          poll_cnt <= 0;
          if (w_q[7:0] == 8'h40) sr_at_stop <= sr_reads;
        end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      arready <= arvalid && !arready && !rvalid;
      if (arvalid && arready) begin
        rvalid <= 1'b1; rresp <= 2'b00;
        if (araddr == 28'h10) begin
          rdata <= {24'h0, (nack_cr != 0 && cr_total - cr_base == nack_cr), 5'b0,
                    (tip_stuck || poll_cnt < 2), 1'b0};
          sr_reads <= sr_reads + 1;
          poll_cnt <= poll_cnt + 1;
        end else if (araddr == 28'h0C) rdata <= {24'h0, rxr_val};
        else rdata <= 32'h0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  typedef struct {
    logic        rw;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [7:0]  wd;
    int          nack;
    int          berr;
    logic [7:0]  rxr;
    logic [7:0]  exp_rdata;
    logic [1:0]  exp_err;
    int          exp_sr;
    int          exp_n;
    logic [63:0] exp_a;
    logic [63:0] exp_d;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(logic rw, logic [6:0] dev, logic [7:0] rg, logic [7:0] wd,
                              int nack, int berr, logic [7:0] rxr, logic [7:0] er,
                              logic [1:0] ee, int esr, int en, logic [63:0] ea, logic [63:0] ed);
    vec_t v;
    v.rw = rw; v.dev = dev; v.rg = rg; v.wd = wd; v.nack = nack; v.berr = berr;
    v.rxr = rxr; v.exp_rdata = er; v.exp_err = ee; v.exp_sr = esr; v.exp_n = en;
    v.exp_a = ea; v.exp_d = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk(name, {31'b0, cmd_ready}, 32'd1);
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk(name, {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
    @(negedge clk);
  endtask

  task automatic check_log(input string name, input int base, input int n,
                           input logic [63:0] ea, input logic [63:0] ed);
    logic [63:0] a, d;
    a = ea; d = ed;
    chk({name, "_count"}, log_addr.size() - base, n);
    for (int i = 0; i < n && base + i < log_addr.size(); i++)
      chk($sformatf("%s_w%0d", name, i),
          {log_addr[base+i][15:0], log_data[base+i][15:0]},
          {8'h00, a[63-8*i -: 8], 8'h00, d[63-8*i -: 8]});
  endtask

  task automatic run_vec(input int k, input vec_t v, input bit hold);
    int lb, sb;
    string nm;
    nm = $sformatf("v%0d", k);
    lb = log_addr.size(); sb = sr_reads;
    wr_base = wr_total; cr_base = cr_total;
    nack_cr = v.nack; berr_wr = v.berr; rxr_val = v.rxr;
    issue(v.rw, v.dev, v.rg, v.wd);
    if (hold) begin
      // a second, different request held high must be ignored while busy
      cmd_rw = ~v.rw; cmd_dev = 7'h11; cmd_reg = 8'h33; cmd_wdata = 8'h77;
    end else cmd_valid = 1'b0;
    wait_rsp({nm, "_rsp"});
    cmd_valid = 1'b0;
    chk({nm, "_rdata"}, {24'h0, rsp_rdata}, {24'h0, v.exp_rdata});
    chk({nm, "_err"}, {30'h0, rsp_err}, {30'h0, v.exp_err});
    chk({nm, "_sr_reads"}, sr_reads - sb, v.exp_sr);
    check_log(nm, lb, v.exp_n, v.exp_a, v.exp_d);
    @(negedge clk);
    chk({nm, "_pulse_len"}, {31'b0, rsp_valid}, 32'd0);
    chk({nm, "_ready_after"}, {30'b0, cmd_ready, busy}, 32'd2);
  endtask

  initial begin
    int lb, sb;
    vecs[0] = mk(1'b0, 7'h50, 8'h12, 8'hA5, 0, 0, 8'h00, 8'h00, 2'b00, 9, 6,
                 64'h0C100C100C100000, 64'hA0901210A5500000);
    vecs[1] = mk(1'b1, 7'h50, 8'h12, 8'h00, 0, 0, 8'h3C, 8'h3C, 2'b00, 12, 7,
                 64'h0C100C100C101000, 64'hA0901210A1906800);
    vecs[2] = mk(1'b0, 7'h50, 8'h12, 8'hA5, 1, 0, 8'h00, 8'h00, 2'b01, 6, 3,
                 64'h0C10100000000000, 64'hA090400000000000);
    vecs[3] = mk(1'b0, 7'h50, 8'h12, 8'hA5, 0, 1, 8'h00, 8'h00, 2'b10, 0, 1,
                 64'h0C00000000000000, 64'hA000000000000000);
    vecs[4] = mk(1'b1, 7'h2A, 8'h07, 8'h00, 2, 0, 8'h99, 8'h00, 2'b01, 9, 5,
                 64'h0C100C1010000000, 64'h5490071040000000);
    vecs[5] = mk(1'b1, 7'h7F, 8'hFF, 8'h00, 0, 7, 8'h55, 8'h00, 2'b10, 9, 7,
                 64'h0C100C100C101000, 64'hFE90FF10FF906800);
    vecs[6] = mk(1'b0, 7'h01, 8'h80, 8'h00, 3, 0, 8'h00, 8'h00, 2'b00, 9, 6,
                 64'h0C100C100C100000, 64'h0290801000500000);
    vecs[7] = mk(1'b1, 7'h50, 8'h12, 8'h00, 3, 0, 8'hC3, 8'h00, 2'b01, 12, 7,
                 64'h0C100C100C101000, 64'hA0901210A1904000);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {26'h0, cmd_ready, rsp_valid, busy, awvalid, wvalid, arvalid},
        {26'h0, 6'b001000});
    rst = 1'b0;
    wait_ready("init_ready");
    check_log("init", 0, 3, 64'h0004080000000000, 64'hC700800000000000);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k], k == 0);

`ifdef I2C_SEQ_TIMEOUT_EN
    // stuck TIP: 8 SR reads, STOP, bounded STOP poll, code 11
    lb = log_addr.size(); sb = sr_reads;
    wr_base = wr_total; cr_base = cr_total; nack_cr = 0; berr_wr = 0;
    tip_stuck = 1'b1;
    issue(1'b0, 7'h50, 8'h12, 8'hA5);
    cmd_valid = 1'b0;
    wait_rsp("to_rsp");
    chk("to_err", {30'h0, rsp_err}, 32'd3);
    chk("to_reads_before_stop", sr_at_stop - sb, 8);
    chk("to_reads_total", sr_reads - sb, 16);
    check_log("to", lb, 3, 64'h0C10100000000000, 64'hA090400000000000);
    tip_stuck = 1'b0;
    @(negedge clk);
`endif

    // reset in the middle of a poll reruns INIT
    wr_base = wr_total; cr_base = cr_total; nack_cr = 0; berr_wr = 0;
    sb = sr_reads;
    tip_stuck = 1'b1;
    issue(1'b0, 7'h50, 8'h12, 8'hA5);
    cmd_valid = 1'b0;
    for (int n = 0; n < 500 && sr_reads - sb < 4; n++) @(negedge clk);
    chk("mid_poll_reached", {31'b0, (sr_reads - sb >= 4)}, 32'd1);
    rst = 1'b1;
    tip_stuck = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs", {26'h0, cmd_ready, rsp_valid, busy, awvalid, wvalid, arvalid},
        {26'h0, 6'b001000});
    lb = log_addr.size();
    prescale = 16'h1234;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("reinit_ready");
    check_log("reinit", lb, 3, 64'h0004080000000000, 64'h3412800000000000);

    // sequencer works again after the reset
    run_vec(8, vecs[1], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
